// File: rtl/seq_det_scheduler_if.sv
// Bundle of requester, grant, result and detector-side signals for the
// shared sequence-detector scheduler.
interface seq_det_scheduler_if #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int FRAME_W = 16,
  parameter int CNT_W   = 5
);
  logic [NREQ-1:0]         req;
  logic [NREQ*FRAME_W-1:0] frame_data;
  logic [NREQ-1:0]         gnt;
  logic                    busy;
  logic                    det_rst_n;
  logic                    det_din;
  logic                    det_flag;
  logic                    done;
  logic [ID_W-1:0]         done_id;
  logic [CNT_W-1:0]        hit_cnt;

  // Environment side: requesters plus the shared detector.
  modport master (
    output req, frame_data, det_flag,
    input  gnt, busy, det_rst_n, det_din, done, done_id, hit_cnt
  );

  // Scheduler side.
  modport slave (
    input  req, frame_data, det_flag,
    output gnt, busy, det_rst_n, det_din, done, done_id, hit_cnt
  );
endinterface

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one 10101010 Moore detector among NREQ
// requesters: clears the detector, shifts one frame in MSB-first, counts
// flag cycles and reports the hit count with the requester id.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a request; detector released, din low
// S_CLEAR  | one-cycle grant pulse, detector held in clear
// S_SHIFT  | FRAME_W cycles driving frame bits MSB-first into the detector
// S_DRAIN  | two cycles covering the detector din-to-flag latency
// S_REPORT | one-cycle done pulse with id and hit count
module seq_det_scheduler #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int FRAME_W = 16,
  parameter int CNT_W   = 5
) (
  input logic                clk,
  input logic                rst,
  seq_det_scheduler_if.slave bus
);

  localparam int TMR_W = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_q, win_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ID_W-1:0]    pick, cand;
  logic               found;
  logic               accept;

  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               det_rst_n_q, det_rst_n_d;
  logic               det_din_q, det_din_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;

  // Round-robin winner: first set request after the last served one.
  always_comb begin
    pick  = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = ID_W'((int'(last_q) + off) % NREQ);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign accept = (state_q == S_IDLE) && found;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; the timer is a down-counter reused by SHIFT and DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_SHIFT;
      S_SHIFT:  if (tmr_q == '0) state_d = S_DRAIN;
      S_DRAIN:  if (tmr_q == '0) state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Saturating hit counter; flags only count while the frame is in flight.
  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = '0;
    else if ((state_q == S_SHIFT || state_q == S_DRAIN) && bus.det_flag && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Frame capture, pointer update, timer and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
      last_q  <= ID_W'(NREQ - 1);
      win_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        S_IDLE: if (accept) begin
          shreg_q <= bus.frame_data[int'(pick)*FRAME_W +: FRAME_W];
          last_q  <= pick;
          win_q   <= pick;
        end
        S_CLEAR: tmr_q <= TMR_W'(FRAME_W - 1);
        S_SHIFT: tmr_q <= (tmr_q == '0) ? TMR_W'(1) : tmr_q - TMR_W'(1);
        S_DRAIN: tmr_q <= tmr_q - TMR_W'(1);
        default: ;
      endcase
      if (state_d == S_SHIFT) shreg_q <= shreg_q << 1;
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    gnt_d       = '0;
    busy_d      = (state_d != S_IDLE);
    det_rst_n_d = (state_d != S_CLEAR);
    det_din_d   = (state_d == S_SHIFT) ? shreg_q[FRAME_W-1] : 1'b0;
    done_d      = (state_d == S_REPORT);
    done_id_d   = done_id_q;
    hit_cnt_d   = hit_cnt_q;
    if (state_d == S_CLEAR) gnt_d = NREQ'(1) << pick;
    if (state_d == S_REPORT) begin
      done_id_d = win_q;
      hit_cnt_d = cnt_d;
    end
  end

  // Output registers; reset holds the detector cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      det_rst_n_q <= 1'b0;
      det_din_q   <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      hit_cnt_q   <= '0;
    end else begin
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      det_rst_n_q <= det_rst_n_d;
      det_din_q   <= det_din_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.det_rst_n = det_rst_n_q;
  assign bus.det_din   = det_din_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler with a behavioural 10101010 detector
// (flag two cycles after the completing din bit) on each scheduler instance.
module tb_seq_det_scheduler;

  logic clk;
  logic rst;

  seq_det_scheduler_if #(.NREQ(4), .ID_W(2), .FRAME_W(16), .CNT_W(5)) bus ();
  seq_det_scheduler_if #(.NREQ(4), .ID_W(2), .FRAME_W(16), .CNT_W(2)) bus_s ();

  seq_det_scheduler #(.NREQ(4), .ID_W(2), .FRAME_W(16), .CNT_W(5)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  seq_det_scheduler #(.NREQ(4), .ID_W(2), .FRAME_W(16), .CNT_W(2)) u_dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector models: 8-bit history, flag registered from the history compare.
  logic [7:0] dsr_a, dsr_b;
  logic       dflag_a, dflag_b;

  always @(posedge clk or negedge bus.det_rst_n) begin
    if (!bus.det_rst_n) begin
      dsr_a   <= '0;
      dflag_a <= 1'b0;
    end else begin
      dsr_a   <= {dsr_a[6:0], bus.det_din};
      dflag_a <= (dsr_a == 8'hAA);
    end
  end

  always @(posedge clk or negedge bus_s.det_rst_n) begin
    if (!bus_s.det_rst_n) begin
      dsr_b   <= '0;
      dflag_b <= 1'b0;
    end else begin
      dsr_b   <= {dsr_b[6:0], bus_s.det_din};
      dflag_b <= (dsr_b == 8'hAA);
    end
  end

  assign bus.det_flag   = dflag_a;
  assign bus_s.det_flag = dflag_b;

  task automatic do_reset();
    rst        = 1'b0;
    bus.req    = '0;
    bus_s.req  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Applies r at an IDLE negedge, captures gnt/det_rst_n in the CLEAR cycle,
  // then waits (bounded) for done. Leaves the bench at the following negedge.
  task automatic serve(input bit sel, input logic [3:0] r, input bit hold,
                       output int cyc, output int id, output int hc,
                       output logic [3:0] g, output logic dr);
    cyc = 0; id = -1; hc = -1; g = 'x; dr = 'x;
    if (sel) bus_s.req = r; else bus.req = r;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        g  = sel ? bus_s.gnt : bus.gnt;
        dr = sel ? bus_s.det_rst_n : bus.det_rst_n;
        if (!hold) begin
          if (sel) bus_s.req = '0; else bus.req = '0;
        end
      end
      if (sel ? bus_s.done : bus.done) begin
        id = sel ? int'(bus_s.done_id) : int'(bus.done_id);
        hc = sel ? int'(bus_s.hit_cnt) : int'(bus.hit_cnt);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.gnt, bus.busy, bus.det_rst_n, bus.det_din, bus.done, bus.done_id, bus.hit_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got gnt=%b busy=%b det_rst_n=%b det_din=%b done=%b id=%0d hit=%0d, want all 0",
               bus.gnt, bus.busy, bus.det_rst_n, bus.det_din, bus.done, bus.done_id, bus.hit_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.det_rst_n, bus.busy, bus.gnt} !== 6'b100000) begin
      miscompares++;
      $display("FAIL idle_after_reset: got det_rst_n=%b busy=%b gnt=%b, want 1 0 0000",
               bus.det_rst_n, bus.busy, bus.gnt);
    end
  endtask

  task automatic test_single();
    int cyc;
    do_reset();
    bus.frame_data[15:0] = 16'hAAAA;
    bus.req = 4'b0001;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0001 || bus.det_rst_n !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL t1_clear_cycle: got gnt=%b det_rst_n=%b busy=%b, want 0001 0 1",
               bus.gnt, bus.det_rst_n, bus.busy);
    end
    bus.req = '0;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0000 || bus.det_rst_n !== 1'b1) begin
      miscompares++;
      $display("FAIL t1_gnt_pulse: got gnt=%b det_rst_n=%b, want 0000 1", bus.gnt, bus.det_rst_n);
    end
    cyc = 2;
    while (!bus.done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 20) begin
      miscompares++;
      $display("FAIL t1_latency: got %0d cycles, want 20", cyc);
    end
    vectors++;
    if (bus.done_id !== 2'd0 || bus.hit_cnt !== 5'd5) begin
      miscompares++;
      $display("FAIL t1_result: got id=%0d hit=%0d, want id=0 hit=5", bus.done_id, bus.hit_cnt);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.done_id !== 2'd0 || bus.hit_cnt !== 5'd5) begin
      miscompares++;
      $display("FAIL t1_hold: got done=%b busy=%b id=%0d hit=%0d, want 0 0 0 5",
               bus.done, bus.busy, bus.done_id, bus.hit_cnt);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] frames [3] = '{16'hAA00, 16'h0000, 16'hFFFF};
    int          hits   [3] = '{1, 0, 0};
    int cyc, id, hc;
    logic [3:0] g;
    logic dr;
    for (int i = 0; i < 3; i++) begin
      bus.frame_data[47:32] = frames[i];
      serve(1'b0, 4'b0100, 1'b0, cyc, id, hc, g, dr);
      vectors++;
      if (cyc !== 20 || id !== 2) begin
        miscompares++;
        $display("FAIL t2_timing[%0d]: got cyc=%0d id=%0d, want 20 2", i, cyc, id);
      end
      vectors++;
      if (hc !== hits[i]) begin
        miscompares++;
        $display("FAIL t2_hits[%0d]: frame=%h got %0d, want %0d", i, frames[i], hc, hits[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] reqs [8] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    int         ids  [8] = '{0, 2, 0, 2, 3, 0, 1, 2};
    int         hits [4] = '{5, 1, 0, 1};
    int cyc, id, hc;
    logic [3:0] g, exp_g;
    logic dr;
    do_reset();
    bus.frame_data = {16'h00AA, 16'h0000, 16'hAA00, 16'hAAAA};
    for (int i = 0; i < 8; i++) begin
      serve(1'b0, reqs[i], (i != 7), cyc, id, hc, g, dr);
      exp_g = 4'b0001 << ids[i];
      vectors++;
      if (cyc !== 20 || id !== ids[i]) begin
        miscompares++;
        $display("FAIL t3_order[%0d]: got cyc=%0d id=%0d, want 20 %0d", i, cyc, id, ids[i]);
      end
      vectors++;
      if (g !== exp_g) begin
        miscompares++;
        $display("FAIL t3_gnt[%0d]: got %b, want %b", i, g, exp_g);
      end
      vectors++;
      if (hc !== hits[ids[i]]) begin
        miscompares++;
        $display("FAIL t3_hits[%0d]: got %0d, want %0d", i, hc, hits[ids[i]]);
      end
    end
  endtask

  task automatic test_saturation();
    int cyc, id, hc;
    logic [3:0] g;
    logic dr;
    do_reset();
    bus_s.frame_data = {48'h0, 16'hAAAA};
    serve(1'b1, 4'b0001, 1'b0, cyc, id, hc, g, dr);
    vectors++;
    if (cyc !== 20 || id !== 0) begin
      miscompares++;
      $display("FAIL t4_timing: got cyc=%0d id=%0d, want 20 0", cyc, id);
    end
    vectors++;
    if (hc !== 3) begin
      miscompares++;
      $display("FAIL t4_saturate: got %0d, want 3", hc);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc, id, hc, pulses;
    logic [3:0] g;
    logic dr;
    do_reset();
    bus.frame_data = {32'h0, 16'hAA00, 16'hAAAA};
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = '0;
    repeat (6) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL t5_in_shift: got busy=%b, want 1", bus.busy);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.gnt, bus.busy, bus.det_rst_n, bus.det_din, bus.done, bus.done_id, bus.hit_cnt} !== '0) begin
      miscompares++;
      $display("FAIL t5_async_clear: got gnt=%b busy=%b det_rst_n=%b det_din=%b done=%b id=%0d hit=%0d, want all 0",
               bus.gnt, bus.busy, bus.det_rst_n, bus.det_din, bus.done, bus.done_id, bus.hit_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL t5_no_done: got %0d active cycles after abandon, want 0", pulses);
    end
    serve(1'b0, 4'b0011, 1'b0, cyc, id, hc, g, dr);
    vectors++;
    if (cyc !== 20 || id !== 0 || hc !== 5) begin
      miscompares++;
      $display("FAIL t5_pointer_reset: got cyc=%0d id=%0d hit=%0d, want 20 0 5", cyc, id, hc);
    end
    do_reset();
    serve(1'b0, 4'b0010, 1'b0, cyc, id, hc, g, dr);
    vectors++;
    if (cyc !== 20 || id !== 1 || hc !== 1 || g !== 4'b0010) begin
      miscompares++;
      $display("FAIL t5_req1: got cyc=%0d id=%0d hit=%0d gnt=%b, want 20 1 1 0010", cyc, id, hc, g);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, id, hc;
    logic [3:0] g;
    logic dr;
    do_reset();
    bus.frame_data = {32'h0, 16'hAA00, 16'h00AA};
    serve(1'b0, 4'b0011, 1'b1, cyc, id, hc, g, dr);
    vectors++;
    if (cyc !== 20 || id !== 0 || hc !== 1) begin
      miscompares++;
      $display("FAIL t6_first: got cyc=%0d id=%0d hit=%0d, want 20 0 1", cyc, id, hc);
    end
    vectors++;
    if (bus.det_rst_n !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_gap_idle: got det_rst_n=%b busy=%b, want 1 0", bus.det_rst_n, bus.busy);
    end
    serve(1'b0, 4'b0011, 1'b0, cyc, id, hc, g, dr);
    vectors++;
    if (dr !== 1'b0 || g !== 4'b0010) begin
      miscompares++;
      $display("FAIL t6_clear_between: got det_rst_n=%b gnt=%b, want 0 0010", dr, g);
    end
    vectors++;
    if (cyc !== 20 || id !== 1 || hc !== 1) begin
      miscompares++;
      $display("FAIL t6_second: got cyc=%0d id=%0d hit=%0d, want 20 1 1", cyc, id, hc);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b0;
    bus.req          = '0;
    bus.frame_data   = '0;
    bus_s.req        = '0;
    bus_s.frame_data = '0;
    test_reset();
    test_single();
    test_patterns();
    test_round_robin();
    test_saturation();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
